// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: EX/MEM -> MEM/WB boundary bundle for the memory stage.
//   ex2mem_*   : instruction fields from the EX/MEM register.
//   mem_flush  : kill the instruction currently in MEM.
//   lsu_*      : variable-latency load response (rvalid is a one-cycle pulse).
//   mem_stall  : back-pressure to EX/MEM and everything upstream.
//   mem2wb_*   : MEM/WB pipeline register contents.
// master = pipeline/LSU side driving the stage, slave = the stage itself.
interface mem_stage_ctrl_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned CSR_OPW = 2
);
  logic               ex2mem_valid;
  logic               ex2mem_reg_wen;
  logic [RF_AW-1:0]   ex2mem_reg_waddr;
  logic [XLEN-1:0]    ex2mem_alu_out;
  logic               ex2mem_mem_rd;
  logic [2:0]         ex2mem_load_fn;
  logic               ex2mem_csr_rd;
  logic [CSR_OPW-1:0] ex2mem_csr_wr_op;
  logic [XLEN-1:0]    ex2mem_csr_wdata;
  logic [CSR_AW-1:0]  ex2mem_csr_addr;
  logic               ex2mem_sel_csr;
  logic               ex2mem_ill_instr;
  logic               mem_flush;
  logic               lsu_rvalid;
  logic [XLEN-1:0]    lsu_rdata;
  logic               mem_stall;
  logic               mem2wb_valid;
  logic               mem2wb_reg_wen;
  logic [RF_AW-1:0]   mem2wb_reg_waddr;
  logic [XLEN-1:0]    mem2wb_reg_wdata;
  logic               mem2wb_csr_rd;
  logic [CSR_OPW-1:0] mem2wb_csr_wr_op;
  logic [XLEN-1:0]    mem2wb_csr_wdata;
  logic [CSR_AW-1:0]  mem2wb_csr_addr;
  logic               mem2wb_sel_csr;
  logic               mem2wb_ill_instr;

  modport master (
    output ex2mem_valid, ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_alu_out,
           ex2mem_mem_rd, ex2mem_load_fn, ex2mem_csr_rd, ex2mem_csr_wr_op,
           ex2mem_csr_wdata, ex2mem_csr_addr, ex2mem_sel_csr, ex2mem_ill_instr,
           mem_flush, lsu_rvalid, lsu_rdata,
    input  mem_stall, mem2wb_valid, mem2wb_reg_wen, mem2wb_reg_waddr,
           mem2wb_reg_wdata, mem2wb_csr_rd, mem2wb_csr_wr_op, mem2wb_csr_wdata,
           mem2wb_csr_addr, mem2wb_sel_csr, mem2wb_ill_instr
  );

  modport slave (
    input  ex2mem_valid, ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_alu_out,
           ex2mem_mem_rd, ex2mem_load_fn, ex2mem_csr_rd, ex2mem_csr_wr_op,
           ex2mem_csr_wdata, ex2mem_csr_addr, ex2mem_sel_csr, ex2mem_ill_instr,
           mem_flush, lsu_rvalid, lsu_rdata,
    output mem_stall, mem2wb_valid, mem2wb_reg_wen, mem2wb_reg_waddr,
           mem2wb_reg_wdata, mem2wb_csr_rd, mem2wb_csr_wr_op, mem2wb_csr_wdata,
           mem2wb_csr_addr, mem2wb_sel_csr, mem2wb_ill_instr
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory pipeline stage between EX/MEM and MEM/WB.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : mem_stage_ctrl_if slave view (ex2mem_* in, lsu_* in,
//              mem_flush in, mem_stall out, mem2wb_* out).
// Waits on a variable-latency LSU response for loads, stalling upstream,
// aligns/extends sub-word load data, and can discard a flushed load's
// response that is still owed by the LSU.
module mem_stage_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned CSR_AW  = 12,
  parameter int unsigned CSR_OPW = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.slave bus
);
  localparam int unsigned OFFW = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            load_req;
  logic            stall;
  logic            cap_valid;
  logic            cap_legal;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  assign load_req = bus.ex2mem_valid & bus.ex2mem_mem_rd;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN keeps stalling until the killed load's response has been swallowed.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (load_req && !bus.lsu_rvalid && !bus.mem_flush) begin
          state_nxt = WAIT;
          stall     = 1'b1;
        end
      end
      WAIT: begin
        if (bus.lsu_rvalid) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (bus.mem_flush) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (bus.lsu_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_stall = stall;

  assign off     = bus.ex2mem_alu_out[OFFW-1:0];
  assign shifted = bus.lsu_rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (bus.ex2mem_load_fn)
      3'b000: load_data = XLEN'($signed(shifted[7:0]));
      3'b100: load_data = XLEN'(shifted[7:0]);
      3'b001: load_data = XLEN'($signed(shifted[15:0]));
      3'b101: load_data = XLEN'(shifted[15:0]);
      3'b010: if (XLEN == 64) load_data = XLEN'($signed(shifted[31:0]));
      3'b110: if (XLEN == 64) load_data = XLEN'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

  assign cap_valid = bus.ex2mem_valid & ~bus.mem_flush & (state != DRAIN);
  assign cap_legal = cap_valid & ~bus.ex2mem_ill_instr;

  // A stalled cycle inserts a bubble; the payload fields keep their value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem2wb_valid     <= 1'b0;
      bus.mem2wb_reg_wen   <= 1'b0;
      bus.mem2wb_reg_waddr <= '0;
      bus.mem2wb_reg_wdata <= '0;
      bus.mem2wb_csr_rd    <= 1'b0;
      bus.mem2wb_csr_wr_op <= '0;
      bus.mem2wb_csr_wdata <= '0;
      bus.mem2wb_csr_addr  <= '0;
      bus.mem2wb_sel_csr   <= 1'b0;
      bus.mem2wb_ill_instr <= 1'b0;
    end else if (stall) begin
      bus.mem2wb_valid <= 1'b0;
    end else begin
      bus.mem2wb_valid     <= cap_valid;
      bus.mem2wb_reg_wen   <= cap_legal & bus.ex2mem_reg_wen & (bus.ex2mem_reg_waddr != '0);
      bus.mem2wb_reg_waddr <= bus.ex2mem_reg_waddr;
      bus.mem2wb_reg_wdata <= bus.ex2mem_mem_rd ? load_data : bus.ex2mem_alu_out;
      bus.mem2wb_csr_rd    <= cap_legal & bus.ex2mem_csr_rd;
      bus.mem2wb_csr_wr_op <= cap_legal ? bus.ex2mem_csr_wr_op : '0;
      bus.mem2wb_csr_wdata <= bus.ex2mem_csr_wdata;
      bus.mem2wb_csr_addr  <= bus.ex2mem_csr_addr;
      bus.mem2wb_sel_csr   <= bus.ex2mem_sel_csr;
      bus.mem2wb_ill_instr <= cap_valid & bus.ex2mem_ill_instr;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: self-checking bench for mem_stage_ctrl (XLEN=32).
// Directed table vectors, hand-written multi-cycle sequences, then random
// traffic compared against a transaction-level reference model.
module tb_mem_stage_ctrl;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned CSR_OPW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.XLEN(XLEN), .RF_AW(RF_AW), .CSR_AW(CSR_AW), .CSR_OPW(CSR_OPW)) bus ();

  mem_stage_ctrl #(.XLEN(XLEN), .RF_AW(RF_AW), .CSR_AW(CSR_AW), .CSR_OPW(CSR_OPW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit owed;     // a load response is still expected from the LSU
  bit killed;   // that outstanding load was flushed
  logic        e_valid, e_wen, e_csr_rd, e_sel, e_ill;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_cwdata;
  logic [1:0]  e_op;
  logic [11:0] e_caddr;

  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint unsigned w, v, lim;
    int unsigned sz;
    bit sgn;
    w = longint'(rdata) >> (8 * (addr % 4));
    case (fn)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd4: begin sz = 1; sgn = 1'b0; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd5: begin sz = 2; sgn = 1'b0; end
      default: return w[31:0];
    endcase
    lim = 64'd1 << (8 * sz);
    v = w % lim;
    if (sgn && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic bit model_stall();
    bit lreq;
    lreq = bus.ex2mem_valid && bus.ex2mem_mem_rd;
    if (owed) return killed || !bus.lsu_rvalid;
    return lreq && !bus.lsu_rvalid && !bus.mem_flush;
  endfunction

  task automatic model_tick();
    bit st, lreq, vv;
    st   = model_stall();
    lreq = bus.ex2mem_valid && bus.ex2mem_mem_rd;
    if (rst) begin
      owed = 0; killed = 0;
      e_valid = 0; e_wen = 0; e_waddr = '0; e_wdata = '0; e_csr_rd = 0;
      e_op = '0; e_cwdata = '0; e_caddr = '0; e_sel = 0; e_ill = 0;
      return;
    end
    if (st) begin
      e_valid = 0;
    end else begin
      vv       = bus.ex2mem_valid && !bus.mem_flush;
      e_valid  = vv;
      e_wen    = vv && bus.ex2mem_reg_wen && !bus.ex2mem_ill_instr && (bus.ex2mem_reg_waddr != 0);
      e_waddr  = bus.ex2mem_reg_waddr;
      e_wdata  = bus.ex2mem_mem_rd ? ref_load(bus.ex2mem_load_fn, bus.ex2mem_alu_out, bus.lsu_rdata)
                                   : bus.ex2mem_alu_out;
      e_csr_rd = vv && bus.ex2mem_csr_rd && !bus.ex2mem_ill_instr;
      e_op     = (vv && !bus.ex2mem_ill_instr) ? bus.ex2mem_csr_wr_op : 2'd0;
      e_cwdata = bus.ex2mem_csr_wdata;
      e_caddr  = bus.ex2mem_csr_addr;
      e_sel    = bus.ex2mem_sel_csr;
      e_ill    = vv && bus.ex2mem_ill_instr;
    end
    if (owed) begin
      if (bus.lsu_rvalid) begin owed = 0; killed = 0; end
      else if (bus.mem_flush) killed = 1;
    end else if (lreq && !bus.lsu_rvalid && !bus.mem_flush) begin
      owed = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic wen, input logic [4:0] wa, input logic [31:0] alu,
                       input logic rd, input logic [2:0] fn, input logic ill, input logic [1:0] op,
                       input logic rv, input logic [31:0] rdata, input logic fl);
    bus.ex2mem_valid     = v;
    bus.ex2mem_reg_wen   = wen;
    bus.ex2mem_reg_waddr = wa;
    bus.ex2mem_alu_out   = alu;
    bus.ex2mem_mem_rd    = rd;
    bus.ex2mem_load_fn   = fn;
    bus.ex2mem_csr_rd    = 1'b0;
    bus.ex2mem_csr_wr_op = op;
    bus.ex2mem_csr_wdata = alu ^ 32'h5A5A_0000;
    bus.ex2mem_csr_addr  = 12'h300;
    bus.ex2mem_sel_csr   = 1'b0;
    bus.ex2mem_ill_instr = ill;
    bus.lsu_rvalid       = rv;
    bus.lsu_rdata        = rdata;
    bus.mem_flush        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // One clock: sample combinational stall mid-cycle, then advance past the edge.
  task automatic clk_cycle(output logic st);
    @(negedge clk);
    st = bus.mem_stall;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic mc_load(input string nm, input logic [2:0] fn, input logic [31:0] alu,
                         input logic [31:0] rdata, input int unsigned lat, input logic [31:0] exp);
    logic st;
    drive(1'b1, 1'b1, 5'd20, alu, 1'b1, fn, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < int'(lat); i++) begin
      clk_cycle(st);
      chk({nm, "_stall"}, 64'(st), 64'(1'b1));
      chk({nm, "_bubble"}, 64'(bus.mem2wb_valid), 64'(1'b0));
    end
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = rdata;
    clk_cycle(st);
    chk({nm, "_done_stall"}, 64'(st), 64'(1'b0));
    chk({nm, "_valid"}, 64'(bus.mem2wb_valid), 64'(1'b1));
    chk({nm, "_wen"}, 64'(bus.mem2wb_reg_wen), 64'(1'b1));
    chk({nm, "_wdata"}, 64'(bus.mem2wb_reg_wdata), 64'(exp));
    idle();
  endtask

  typedef struct {
    logic v, wen; logic [4:0] wa; logic [31:0] alu; logic rd; logic [2:0] fn;
    logic ill; logic [1:0] op; logic rv; logic [31:0] rdata; logic fl;
    logic e_v, e_wen; logic [31:0] e_wd; logic [1:0] e_op; logic e_ill;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic st;
    logic es;
    logic prev_stall;

    tbl[0]  = '{1'b1,1'b1,5'd5, 32'h1234,1'b0,3'd0,1'b0,2'd0,1'b0,32'h0,1'b0,        1'b1,1'b1,32'h1234,2'd0,1'b0};
    tbl[1]  = '{1'b1,1'b1,5'd3, 32'h55,  1'b0,3'd0,1'b1,2'd2,1'b0,32'h0,1'b0,        1'b1,1'b0,32'h55,2'd0,1'b1};
    tbl[2]  = '{1'b1,1'b1,5'd0, 32'h77,  1'b0,3'd0,1'b0,2'd0,1'b0,32'h0,1'b0,        1'b1,1'b0,32'h77,2'd0,1'b0};
    tbl[3]  = '{1'b1,1'b0,5'd7, 32'h99,  1'b0,3'd0,1'b0,2'd3,1'b0,32'h0,1'b0,        1'b1,1'b0,32'h99,2'd3,1'b0};
    tbl[4]  = '{1'b1,1'b1,5'd9, 32'h101, 1'b1,3'd0,1'b0,2'd0,1'b1,32'h0000F000,1'b0, 1'b1,1'b1,32'hFFFFFFF0,2'd0,1'b0};
    tbl[5]  = '{1'b1,1'b1,5'd10,32'h2002,1'b1,3'd5,1'b0,2'd0,1'b1,32'hBEEF0000,1'b0, 1'b1,1'b1,32'h0000BEEF,2'd0,1'b0};
    tbl[6]  = '{1'b1,1'b1,5'd11,32'h40,  1'b1,3'd2,1'b0,2'd0,1'b1,32'h87654321,1'b0, 1'b1,1'b1,32'h87654321,2'd0,1'b0};
    tbl[7]  = '{1'b0,1'b1,5'd12,32'h5,   1'b0,3'd0,1'b0,2'd1,1'b0,32'h0,1'b0,        1'b0,1'b0,32'h5,2'd0,1'b0};
    tbl[8]  = '{1'b1,1'b1,5'd13,32'h6,   1'b0,3'd0,1'b0,2'd1,1'b0,32'h0,1'b1,        1'b0,1'b0,32'h6,2'd0,1'b0};
    tbl[9]  = '{1'b1,1'b1,5'd14,32'h0,   1'b1,3'd1,1'b0,2'd0,1'b1,32'h00008001,1'b0, 1'b1,1'b1,32'hFFFF8001,2'd0,1'b0};
    tbl[10] = '{1'b1,1'b1,5'd15,32'hABC, 1'b0,3'd0,1'b0,2'd0,1'b1,32'hFFFFFFFF,1'b0, 1'b1,1'b1,32'hABC,2'd0,1'b0};

    // Reset state
    rst = 1'b1;
    idle();
    clk_cycle(st);
    clk_cycle(st);
    chk("rst_valid", 64'(bus.mem2wb_valid), 64'(1'b0));
    chk("rst_wen", 64'(bus.mem2wb_reg_wen), 64'(1'b0));
    chk("rst_wdata", 64'(bus.mem2wb_reg_wdata), 64'(32'd0));
    chk("rst_csr_op", 64'(bus.mem2wb_csr_wr_op), 64'(2'd0));
    chk("rst_ill", 64'(bus.mem2wb_ill_instr), 64'(1'b0));
    chk("rst_stall", 64'(st), 64'(1'b0));
    rst = 1'b0;

    // Single-cycle table vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].wen, tbl[i].wa, tbl[i].alu, tbl[i].rd, tbl[i].fn,
            tbl[i].ill, tbl[i].op, tbl[i].rv, tbl[i].rdata, tbl[i].fl);
      clk_cycle(st);
      chk($sformatf("vec%0d_stall", i), 64'(st), 64'(1'b0));
      chk($sformatf("vec%0d_valid", i), 64'(bus.mem2wb_valid), 64'(tbl[i].e_v));
      chk($sformatf("vec%0d_wen", i), 64'(bus.mem2wb_reg_wen), 64'(tbl[i].e_wen));
      chk($sformatf("vec%0d_wdata", i), 64'(bus.mem2wb_reg_wdata), 64'(tbl[i].e_wd));
      chk($sformatf("vec%0d_csr_op", i), 64'(bus.mem2wb_csr_wr_op), 64'(tbl[i].e_op));
      chk($sformatf("vec%0d_ill", i), 64'(bus.mem2wb_ill_instr), 64'(tbl[i].e_ill));
    end
    idle();
    clk_cycle(st);

    // Multi-cycle loads, response three cycles late
    mc_load("lb",  3'd0, 32'h0000_1003, 32'h8012_3456, 3, 32'hFFFF_FF80);
    mc_load("lbu", 3'd4, 32'h0000_1003, 32'h8012_3456, 3, 32'h0000_0080);
    mc_load("lhu", 3'd5, 32'h0000_1002, 32'hBEEF_0000, 3, 32'h0000_BEEF);

    // Flush while waiting: DRAIN swallows the late response
    drive(1'b1, 1'b1, 5'd21, 32'h100, 1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
    clk_cycle(st);
    chk("fl_issue_stall", 64'(st), 64'(1'b1));
    bus.mem_flush = 1'b1;
    clk_cycle(st);
    chk("fl_flush_stall", 64'(st), 64'(1'b1));
    chk("fl_flush_valid", 64'(bus.mem2wb_valid), 64'(1'b0));
    bus.mem_flush = 1'b0;
    clk_cycle(st);
    chk("fl_drain_stall", 64'(st), 64'(1'b1));
    chk("fl_drain_valid", 64'(bus.mem2wb_valid), 64'(1'b0));
    bus.lsu_rvalid = 1'b1;
    bus.lsu_rdata  = 32'hDEAD_BEEF;
    clk_cycle(st);
    chk("fl_resp_stall", 64'(st), 64'(1'b1));
    chk("fl_resp_valid", 64'(bus.mem2wb_valid), 64'(1'b0));
    drive(1'b1, 1'b1, 5'd22, 32'h4242, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
    clk_cycle(st);
    chk("fl_next_stall", 64'(st), 64'(1'b0));
    chk("fl_next_valid", 64'(bus.mem2wb_valid), 64'(1'b1));
    chk("fl_next_wdata", 64'(bus.mem2wb_reg_wdata), 64'(32'h4242));

    // Reset while waiting
    drive(1'b1, 1'b1, 5'd23, 32'h200, 1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
    clk_cycle(st);
    chk("rw_wait_stall", 64'(st), 64'(1'b1));
    rst = 1'b1;
    idle();
    clk_cycle(st);
    chk("rw_valid", 64'(bus.mem2wb_valid), 64'(1'b0));
    chk("rw_waddr", 64'(bus.mem2wb_reg_waddr), 64'(5'd0));
    chk("rw_wdata", 64'(bus.mem2wb_reg_wdata), 64'(32'd0));
    chk("rw_csr_addr", 64'(bus.mem2wb_csr_addr), 64'(12'd0));
    rst = 1'b0;
    clk_cycle(st);
    chk("rw_after_stall", 64'(st), 64'(1'b0));

    // Random traffic against the reference model
    prev_stall = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!prev_stall) begin
        bus.ex2mem_valid     = ($urandom_range(0, 3) != 0);
        bus.ex2mem_reg_wen   = 1'($urandom);
        bus.ex2mem_reg_waddr = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
        bus.ex2mem_alu_out   = $urandom;
        bus.ex2mem_mem_rd    = 1'($urandom);
        bus.ex2mem_load_fn   = 3'($urandom);
        bus.ex2mem_csr_rd    = 1'($urandom);
        bus.ex2mem_csr_wr_op = 2'($urandom);
        bus.ex2mem_csr_wdata = $urandom;
        bus.ex2mem_csr_addr  = 12'($urandom);
        bus.ex2mem_sel_csr   = 1'($urandom);
        bus.ex2mem_ill_instr = ($urandom_range(0, 7) == 0);
      end
      bus.mem_flush = ($urandom_range(0, 9) == 0);
      if (owed || (bus.ex2mem_valid && bus.ex2mem_mem_rd))
        bus.lsu_rvalid = ($urandom_range(0, 2) == 0);
      else
        bus.lsu_rvalid = ($urandom_range(0, 7) == 0);
      bus.lsu_rdata = $urandom;
      es = model_stall();
      clk_cycle(st);
      chk("rnd_stall", 64'(st), 64'(es));
      chk("rnd_valid", 64'(bus.mem2wb_valid), 64'(e_valid));
      chk("rnd_wen", 64'(bus.mem2wb_reg_wen), 64'(e_wen));
      chk("rnd_waddr", 64'(bus.mem2wb_reg_waddr), 64'(e_waddr));
      chk("rnd_wdata", 64'(bus.mem2wb_reg_wdata), 64'(e_wdata));
      chk("rnd_csr_rd", 64'(bus.mem2wb_csr_rd), 64'(e_csr_rd));
      chk("rnd_csr_op", 64'(bus.mem2wb_csr_wr_op), 64'(e_op));
      chk("rnd_csr_wdata", 64'(bus.mem2wb_csr_wdata), 64'(e_cwdata));
      chk("rnd_csr_addr", 64'(bus.mem2wb_csr_addr), 64'(e_caddr));
      chk("rnd_sel_csr", 64'(bus.mem2wb_sel_csr), 64'(e_sel));
      chk("rnd_ill", 64'(bus.mem2wb_ill_instr), 64'(e_ill));
      prev_stall = es && !rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
